// File: rtl/block_mem_writer_pkg.sv
// rtl/block_mem_writer_pkg.sv - shared encodings for the block sprite memory writer
//   OP_*     : fill command encodings
//   PIX_*    : 2-bit pixel codes stored in block memory
//   V_ACTIVE : first vcount of vertical blanking, shared with timing gen and drawers
//   wr_state_t : writer FSM states
package block_mem_writer_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_SOLID  = 2'b01;
  localparam logic [1:0] OP_BORDER = 2'b10;

  localparam logic [1:0] PIX_BLACK = 2'b00;
  localparam logic [1:0] PIX_FILL  = 2'b01;
  localparam logic [1:0] PIX_WHITE = 2'b11;

  localparam int V_ACTIVE = 600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/block_mem_writer_pattern_gen.sv
// rtl/block_mem_writer_pattern_gen.sv - combinational pixel pattern for one block position
//   op  in  2      latched fill op (11 behaves as clear)
//   row in  ROW_W  current row, 0..BLK_H-1
//   col in  COL_W  current column, 0..BLK_W-1
//   pix out 2      pixel code for (row, col)
module block_pattern_gen
  import block_mem_writer_pkg::*;
#(
  parameter int BLK_W = 104,
  parameter int BLK_H = 28,
  parameter int ROW_W = 5,
  parameter int COL_W = 7
) (
  input  logic [1:0]       op,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [1:0]       pix
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BLK_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BLK_W - 1);

  logic on_edge;

  always_comb begin
    on_edge = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    pix     = PIX_BLACK;
    case (op)
      OP_SOLID:  pix = PIX_FILL;
      OP_BORDER: pix = on_edge ? PIX_WHITE : PIX_FILL;
      default:   pix = PIX_BLACK;
    endcase
  end

endmodule

// File: rtl/block_mem_writer.sv
// rtl/block_mem_writer.sv - fills the block sprite memory one pixel per clock during vblank
//   vclk, rst            pixel clock, synchronous active-high reset
//   vcount               raster line; writes only when vcount >= V_ACTIVE
//   cmd_valid/cmd_op     fill command (clear / solid / bordered)
//   cmd_ready            high only while idle
//   mem_we/addr/wdata    block memory write port, row-major from address 0
//   busy                 acceptance through the done cycle
//   done                 one-cycle pulse after the last pixel
module block_mem_writer #(
  parameter int BLK_W    = 104,
  parameter int BLK_H    = 28,
  parameter int ADDR_W   = 12,
  parameter int V_ACTIVE = block_mem_writer_pkg::V_ACTIVE
) (
  input  logic              vclk,
  input  logic              rst,
  input  logic [9:0]        vcount,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  output logic              busy,
  output logic              done
);

  import block_mem_writer_pkg::*;

  localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int COL_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(BLK_H - 1);
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(BLK_W - 1);
  localparam logic [9:0]       V_BLANK_LINE = 10'(V_ACTIVE);

  wr_state_t         state;
  logic [1:0]        op_q;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        pix;
  logic              in_blank;

  assign in_blank = (vcount >= V_BLANK_LINE);

  block_pattern_gen #(
    .BLK_W (BLK_W),
    .BLK_H (BLK_H),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pattern (
    .op  (op_q),
    .row (row),
    .col (col),
    .pix (pix)
  );

  // The address runs as its own counter alongside row/col so no multiplier
  // is needed to linearise the position.
  always_ff @(posedge vclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_CLEAR;
      row       <= '0;
      col       <= '0;
      addr_cnt  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= PIX_BLACK;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            row       <= '0;
            col       <= '0;
            addr_cnt  <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Address tracks the counter even while paused, so a stalled
          // fill shows the next pixel to be written.
          mem_addr <= addr_cnt;
          if (in_blank) begin
            mem_we    <= 1'b1;
            mem_wdata <= pix;
            addr_cnt  <= addr_cnt + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state <= ST_DONE;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
